mem_arbiter: RTL and testbench

//  Two-to-one memory arbiter directly downstream of the CPU's two memory ports.

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter_grant.sv | 47 ++++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 tb/tb_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// lc3b_types
//   Shared LC-3b memory-side types used by the two-port memory arbiter.
//   lc3b_word       16-bit address/data word
//   lc3b_mem_wmask  2-bit byte write mask (bit 0 = low byte)
//   mem_arb_state_t arbiter FSM state
//   arb_port_t      identifies an upstream port (A = fetch, B = data)
// ----------------------------------------------------------------------------
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_A = 2'd1,
        SERVE_B = 2'd2
    } mem_arb_state_t;

    typedef enum logic {
        ARB_A = 1'b0,
        ARB_B = 1'b1
    } arb_port_t;

endpackage

// File: rtl/mem_arbiter_grant.sv
// ----------------------------------------------------------------------------
// mem_arbiter_grant
//   Combinational grant selection between the two upstream ports.
//   Build option: MEM_ARB_ROUND_ROBIN_EN
//     undefined : fixed priority, B (data) always beats A (fetch)
//     defined   : on a tie, the port that did not win last time is granted
//   Ports:
//     req_a, req_b  in   port A / B currently requesting
//     last_grant    in   port served by the most recent transaction (arb_port_t)
//     grant         out  selected port (arb_port_t); only meaningful when a
//                        request is present
// ----------------------------------------------------------------------------
module mem_arbiter_grant
    import lc3b_types::*;
(
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    output logic grant
);

    arb_port_t sel;

    always_comb begin
        sel = arb_port_t'(last_grant);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (req_a && req_b) begin
            sel = (arb_port_t'(last_grant) == ARB_A) ? ARB_B : ARB_A;
        end else if (req_b) begin
            sel = ARB_B;
        end else if (req_a) begin
            sel = ARB_A;
        end
`else
        if (req_b) begin
            sel = ARB_B;
        end else if (req_a) begin
            sel = ARB_A;
        end
`endif
        // With nothing requesting the selection parks on the previous
        // winner; the FSM ignores it in that case.
    end

    assign grant = sel;

endmodule

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//   Two-to-one arbiter placing the CPU fetch port (A) and data port (B) onto
//   one single-ported physical memory and steering each completion back.
//   Build option: MEM_ARB_ROUND_ROBIN_EN (see mem_arbiter_grant).
//
//   Handshake (upstream and pmem alike): the requester raises read or write
//   as a level together with address/wdata/wmask and holds them until the
//   one-cycle resp pulse; read data is valid only in the resp cycle. Raising
//   read and write together is treated as a write.
//
//   Ports:
//     clk, rst_n                  clock, async active-low reset
//     read_x/write_x/wmask_x/
//     address_x/wdata_x           port x request (x = a, b)
//     resp_x/rdata_x              port x completion pulse and read data
//     pmem_read/write/wmask/
//     address/wdata               memory request, driven only while serving
//     pmem_resp/pmem_rdata        memory completion and read data
//     dbg_state                   current FSM state (mem_arb_state_t encoding)
// ----------------------------------------------------------------------------
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_W = $bits(lc3b_word),
    parameter int DATA_W = $bits(lc3b_word),
    parameter int MASK_W = $bits(lc3b_mem_wmask)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_a,
    input  logic              write_a,
    input  logic [MASK_W-1:0] wmask_a,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              resp_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              read_b,
    input  logic              write_b,
    input  logic [MASK_W-1:0] wmask_b,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              resp_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [MASK_W-1:0] pmem_wmask,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [DATA_W-1:0] pmem_wdata,
    input  logic              pmem_resp,
    input  logic [DATA_W-1:0] pmem_rdata,
    output logic [1:0]        dbg_state
);

    mem_arb_state_t    state;
    mem_arb_state_t    state_next;
    arb_port_t         last_grant;
    logic              grant;
    logic              req_a;
    logic              req_b;

    // Request registers: the memory sees only these, so upstream changes
    // during a transaction cannot disturb it.
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [MASK_W-1:0] req_wmask;

    assign req_a = read_a | write_a;
    assign req_b = read_b | write_b;

    mem_arbiter_grant u_grant (
        .req_a      (req_a),
        .req_b      (req_b),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= ARB_A;
            req_we     <= 1'b0;
            req_addr   <= '0;
            req_wdata  <= '0;
            req_wmask  <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && (req_a || req_b)) begin
                if (arb_port_t'(grant) == ARB_B) begin
                    req_we    <= write_b;
                    req_addr  <= address_b;
                    req_wdata <= wdata_b;
                    req_wmask <= wmask_b;
                end else begin
                    req_we    <= write_a;
                    req_addr  <= address_a;
                    req_wdata <= wdata_a;
                    req_wmask <= wmask_a;
                end
            end
            if (pmem_resp) begin
                if (state == SERVE_A) last_grant <= ARB_A;
                if (state == SERVE_B) last_grant <= ARB_B;
            end
        end
    end

    always_comb begin
        state_next   = state;
        resp_a       = 1'b0;
        rdata_a      = '0;
        resp_b       = 1'b0;
        rdata_b      = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_wmask   = '0;
        pmem_address = '0;
        pmem_wdata   = '0;

        case (state)
            IDLE: begin
                if (req_a || req_b) begin
                    state_next = (arb_port_t'(grant) == ARB_B) ? SERVE_B : SERVE_A;
                end
            end
            SERVE_A, SERVE_B: begin
                pmem_read    = ~req_we;
                pmem_write   = req_we;
                pmem_wmask   = req_wmask;
                pmem_address = req_addr;
                pmem_wdata   = req_wdata;
                if (pmem_resp) begin
                    // Always return to IDLE: the idle cycle gives the
                    // requester time to drop its level request.
                    state_next = IDLE;
                    if (state == SERVE_A) begin
                        resp_a  = 1'b1;
                        rdata_a = pmem_rdata;
                    end else begin
                        resp_b  = 1'b1;
                        rdata_b = pmem_rdata;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
    import lc3b_types::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        read_a = 0, write_a = 0, read_b = 0, write_b = 0;
    logic [1:0]  wmask_a = 0, wmask_b = 0;
    logic [15:0] address_a = 0, wdata_a = 0, address_b = 0, wdata_b = 0;
    logic        resp_a, resp_b;
    logic [15:0] rdata_a, rdata_b;
    logic        pmem_read, pmem_write;
    logic [1:0]  pmem_wmask;
    logic [15:0] pmem_address, pmem_wdata;
    logic        pmem_resp = 0;
    logic [15:0] pmem_rdata = 0;
    logic [1:0]  dbg_state;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .read_a(read_a), .write_a(write_a), .wmask_a(wmask_a), .address_a(address_a),
        .wdata_a(wdata_a), .resp_a(resp_a), .rdata_a(rdata_a),
        .read_b(read_b), .write_b(write_b), .wmask_b(wmask_b), .address_b(address_b),
        .wdata_b(wdata_b), .resp_b(resp_b), .rdata_b(rdata_b),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_wmask(pmem_wmask),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [15:0] exp_a_q[$];
    logic [15:0] exp_b_q[$];
    logic [34:0] exp_pmem_q[$];  // {we, addr, wdata, wmask}
    int checks = 0;
    int errors = 0;
    int pmem_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_pmem(input bit we, input logic [15:0] addr,
                             input logic [15:0] wd, input logic [1:0] wm);
        exp_pmem_q.push_back({we, addr, wd, wm});
    endtask

    // ---------------- memory model ----------------
    logic [15:0] mem [logic [15:0]];
    int          mem_cycles = 1;
    int          cnt = 0;
    int          spur_cnt = 0, spur_seen = 0;
    logic [15:0] hold_addr;
    logic        hold_we;

    always @(negedge clk) begin
        if (!rst_n) begin
            cnt = 0; pmem_resp = 0; pmem_rdata = 0;
        end else if (pmem_read || pmem_write) begin
            if (cnt == 0) begin
                hold_addr = pmem_address;
                hold_we   = pmem_write;
            end else begin
                check("pmem_addr_held", pmem_address, hold_addr);
                check("pmem_op_held", pmem_write, hold_we);
            end
            cnt++;
            if (cnt == mem_cycles) begin
                pmem_resp = 1;
                if (pmem_write) begin
                    if (!mem.exists(pmem_address)) mem[pmem_address] = 16'h0;
                    if (pmem_wmask[0]) mem[pmem_address][7:0]  = pmem_wdata[7:0];
                    if (pmem_wmask[1]) mem[pmem_address][15:8] = pmem_wdata[15:8];
                    pmem_rdata = 16'h0;
                end else begin
                    pmem_rdata = mem[pmem_address];
                end
                cnt = 0;
            end else begin
                pmem_resp = 0; pmem_rdata = 0;
            end
        end else begin
            if (cnt != 0) begin
                checks++; errors++;
                $display("FAIL strobe_dropped after %0d cycles, required hold %0d", cnt, mem_cycles);
            end
            cnt = 0;
            if (spur_cnt != spur_seen) begin
                spur_seen  = spur_cnt;
                pmem_resp  = 1;
                pmem_rdata = 16'hFFFF;
            end else begin
                pmem_resp = 0; pmem_rdata = 0;
            end
        end
    end

    // ---------------- monitor ----------------
    logic prev_resp = 0;
    always @(negedge clk) begin
        #2;
        if (read_a && write_a) $display("note: illegal read+write on port A");
        if (read_b && write_b) $display("note: illegal read+write on port B");
        if (resp_a) begin
            if (exp_a_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL resp_a_unexpected actual=1 required=0 at %0t", $time);
            end else check("rdata_a", rdata_a, exp_a_q.pop_front());
        end else check("rdata_a_idle", rdata_a, 16'h0);
        if (resp_b) begin
            if (exp_b_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL resp_b_unexpected actual=1 required=0 at %0t", $time);
            end else check("rdata_b", rdata_b, exp_b_q.pop_front());
        end else check("rdata_b_idle", rdata_b, 16'h0);
        if (prev_resp) check("idle_gap_strobe", {pmem_read, pmem_write}, 2'b00);
        if (pmem_read || pmem_write) check("pmem_excl", pmem_read & pmem_write, 1'b0);
        if (pmem_resp && (pmem_read || pmem_write)) begin
            logic [34:0] e;
            pmem_done++;
            if (exp_pmem_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL pmem_unexpected addr=%h", pmem_address);
            end else begin
                e = exp_pmem_q.pop_front();
                check("pmem_op", pmem_write, e[34]);
                check("pmem_addr", pmem_address, e[33:18]);
                if (e[34]) begin
                    check("pmem_wdata", pmem_wdata, e[17:2]);
                    check("pmem_wmask", pmem_wmask, e[1:0]);
                end
            end
        end
        prev_resp = resp_a | resp_b;
    end

    // ---------------- driver ----------------
    task automatic drive(input bit pb, input bit we, input logic [15:0] addr,
                         input logic [15:0] wd, input logic [1:0] wm,
                         input logic [15:0] exp_rd, input bit keep);
        bit got = 0;
        if (pb) begin
            exp_b_q.push_back(exp_rd);
            read_b = !we; write_b = we; address_b = addr; wdata_b = wd; wmask_b = wm;
        end else begin
            exp_a_q.push_back(exp_rd);
            read_a = !we; write_a = we; address_a = addr; wdata_a = wd; wmask_a = wm;
        end
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk); #2;
            got = pb ? resp_b : resp_a;
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL timeout port=%s addr=%h no resp", pb ? "B" : "A", addr);
        end
        @(negedge clk);
        if (!keep) begin
            if (pb) begin read_b = 0; write_b = 0; end
            else begin read_a = 0; write_a = 0; end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int a_start, a_span;
        mem[16'h0040] = 16'hBEEF; mem[16'h1002] = 16'h5A5A;
        mem[16'h2000] = 16'h1111; mem[16'h0042] = 16'hAAAA; mem[16'h2002] = 16'hBBBB;
        mem[16'h0044] = 16'hA044; mem[16'h3000] = 16'hB300; mem[16'h3002] = 16'hB302;
        mem[16'h3004] = 16'hB304; mem[16'h0046] = 16'h0046; mem[16'h0100] = 16'hC100;
        mem[16'h0200] = 16'hDEAD;

        // reset state
        repeat (2) @(negedge clk); #2;
        check("rst_state", dbg_state, 2'(IDLE));
        check("rst_pmem_strobes", {pmem_read, pmem_write}, 2'b00);
        check("rst_pmem_bus", {pmem_address, pmem_wdata, pmem_wmask}, 34'h0);
        check("rst_resp", {resp_a, resp_b}, 2'b00);
        #1 rst_n = 1;

        // 1: single zero-wait read on A
        @(negedge clk);
        mem_cycles = 1;
        push_pmem(0, 16'h0040, 16'h0, 2'b00);
        fork
            drive(0, 0, 16'h0040, 16'h0, 2'b00, 16'hBEEF, 0);
            begin
                @(negedge clk); #2;
                check("t1_pmem_read", pmem_read, 1'b1);
                check("t1_pmem_addr", pmem_address, 16'h0040);
                check("t1_resp_a", resp_a, 1'b1);
                check("t1_rdata_a", rdata_a, 16'hBEEF);
                check("t1_resp_b", resp_b, 1'b0);
            end
        join
        @(negedge clk);

        // 2: masked write on B, 3-cycle memory
        mem_cycles = 3;
        push_pmem(1, 16'h1002, 16'h00A5, 2'b01);
        drive(1, 1, 16'h1002, 16'h00A5, 2'b01, 16'h0000, 0);
        check("t2_mem_merge", mem[16'h1002], 16'h5AA5);
        mem_cycles = 1;
        @(negedge clk);

        // 3: lone B read, then A and B tie
        push_pmem(0, 16'h2000, 16'h0, 2'b00);
        drive(1, 0, 16'h2000, 16'h0, 2'b00, 16'h1111, 0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        push_pmem(0, 16'h0042, 16'h0, 2'b00);
        push_pmem(0, 16'h2002, 16'h0, 2'b00);
`else
        push_pmem(0, 16'h2002, 16'h0, 2'b00);
        push_pmem(0, 16'h0042, 16'h0, 2'b00);
`endif
        fork
            drive(0, 0, 16'h0042, 16'h0, 2'b00, 16'hAAAA, 0);
            drive(1, 0, 16'h2002, 16'h0, 2'b00, 16'hBBBB, 0);
        join
        @(negedge clk);

        // 4: A against back-to-back B traffic
`ifdef MEM_ARB_ROUND_ROBIN_EN
        push_pmem(0, 16'h0044, 16'h0, 2'b00);
        push_pmem(0, 16'h3000, 16'h0, 2'b00);
        push_pmem(0, 16'h3002, 16'h0, 2'b00);
        push_pmem(0, 16'h3004, 16'h0, 2'b00);
`else
        push_pmem(0, 16'h3000, 16'h0, 2'b00);
        push_pmem(0, 16'h3002, 16'h0, 2'b00);
        push_pmem(0, 16'h3004, 16'h0, 2'b00);
        push_pmem(0, 16'h0044, 16'h0, 2'b00);
`endif
        a_start = pmem_done;
        fork
            begin
                drive(0, 0, 16'h0044, 16'h0, 2'b00, 16'hA044, 0);
                a_span = pmem_done - a_start;
            end
            begin
                drive(1, 0, 16'h3000, 16'h0, 2'b00, 16'hB300, 1);
                drive(1, 0, 16'h3002, 16'h0, 2'b00, 16'hB302, 1);
                drive(1, 0, 16'h3004, 16'h0, 2'b00, 16'hB304, 0);
            end
        join
`ifdef MEM_ARB_ROUND_ROBIN_EN
        check("t4_a_wait_txns", a_span, 1);
`else
        check("t4_a_wait_txns", a_span, 4);
`endif
        @(negedge clk);

        // 5: reset in SERVE_A while memory holds off
        mem_cycles = 20;
        read_a = 1; address_a = 16'h0046;
        repeat (2) @(negedge clk); #2;
        check("t5_pmem_read", pmem_read, 1'b1);
        check("t5_pmem_addr", pmem_address, 16'h0046);
        #1 rst_n = 0;
        #1;
        check("t5_rst_state", dbg_state, 2'(IDLE));
        check("t5_rst_pmem", {pmem_read, pmem_write, pmem_address, pmem_wdata, pmem_wmask}, 36'h0);
        check("t5_rst_resp", {resp_a, resp_b, rdata_a, rdata_b}, 34'h0);
        @(negedge clk);
        read_a = 0;
        @(negedge clk); #1 rst_n = 1;
        repeat (4) @(negedge clk);
        mem_cycles = 1;
        push_pmem(0, 16'h1002, 16'h0, 2'b00);
        drive(0, 0, 16'h1002, 16'h0, 2'b00, 16'h5AA5, 0);
        @(negedge clk);

        // 6: spurious pmem_resp in IDLE, then address change mid-SERVE_A
        #1 spur_cnt++;
        @(negedge clk); #2;
        check("t6_spur_resp", {resp_a, resp_b}, 2'b00);
        check("t6_spur_state", dbg_state, 2'(IDLE));
        @(negedge clk);
        mem_cycles = 3;
        push_pmem(0, 16'h0100, 16'h0, 2'b00);
        fork
            drive(0, 0, 16'h0100, 16'h0, 2'b00, 16'hC100, 0);
            begin
                repeat (2) @(negedge clk);
                address_a = 16'h0200;
            end
        join

        repeat (5) @(negedge clk);
        check("end_exp_a_empty", exp_a_q.size(), 0);
        check("end_exp_b_empty", exp_b_q.size(), 0);
        check("end_exp_pmem_empty", exp_pmem_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
